// File: rtl/score_accumulator.sv
// Score keeper for a shooter game: adds alien kill values and an end-of-game
// accuracy bonus to a two-digit BCD score (tens units), saturating at 990.
module score_accumulator #(
    parameter int BONUS_BASE = 21,
    parameter int BONUS_MAX  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] curr_state,
    input  logic       point_valid,
    input  logic [1:0] point_type,
    input  logic [9:0] fire_count,
    output logic       point_ready,
    output logic [3:0] hundreds,
    output logic [3:0] ten_out,
    output logic       busy,
    output logic       saturated,
    output logic       bonus_given
);

    localparam int RW = ($clog2(BONUS_MAX + 1) > 2) ? $clog2(BONUS_MAX + 1) : 2;

    typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [RW-1:0] r_remain;
    logic [RW-1:0] w_remainNext;
    logic [3:0]    r_hundreds;
    logic [3:0]    r_tens;
    logic [3:0]    w_hundredsNext;
    logic [3:0]    w_tensNext;
    logic [3:0]    w_incHundreds;
    logic [3:0]    w_incTens;
    logic          r_saturated;
    logic          w_satNext;
    logic          r_bonusGiven;
    logic          w_givenNext;
    logic          r_bonusPending;
    logic          w_pendingNext;
    logic [2:0]    r_prevState;
    logic          w_clear;
    logic          w_accept;
    logic          w_win;
    logic          w_bonusReq;
    int            w_excess;
    int            w_bonusInt;
    logic [RW-1:0] w_bonus;

    assign w_clear     = (curr_state == 3'd0) || (curr_state == 3'd6);
    assign point_ready = (r_state == IDLE) && !w_clear;
    assign busy        = (r_state == ADD);
    assign w_accept    = point_valid && point_ready && (point_type != 2'd0);
    assign w_win       = (curr_state == 3'd4) && (r_prevState != 3'd4) && !r_bonusGiven;
    assign w_bonusReq  = r_bonusPending || w_win;

    assign hundreds    = r_hundreds;
    assign ten_out     = r_tens;
    assign saturated   = r_saturated;
    assign bonus_given = r_bonusGiven;

    // Bonus shrinks by one tens unit per shot beyond the free allowance.
    always_comb begin
        w_excess = int'(fire_count) - BONUS_BASE;
        if (w_excess <= 0) begin
            w_bonusInt = BONUS_MAX;
        end else if (w_excess >= BONUS_MAX) begin
            w_bonusInt = 0;
        end else begin
            w_bonusInt = BONUS_MAX - w_excess;
        end
    end

    assign w_bonus = RW'(w_bonusInt);

    always_comb begin
        w_incHundreds = r_hundreds;
        w_incTens     = r_tens;
        if (!(r_hundreds == 4'd9 && r_tens == 4'd9)) begin
            if (r_tens == 4'd9) begin
                w_incTens     = 4'd0;
                w_incHundreds = r_hundreds + 4'd1;
            end else begin
                w_incTens = r_tens + 4'd1;
            end
        end
    end

    // A point accept wins over a pending bonus; the bonus waits for a free IDLE edge.
    always_comb begin
        w_stateNext    = r_state;
        w_remainNext   = r_remain;
        w_hundredsNext = r_hundreds;
        w_tensNext     = r_tens;
        w_satNext      = r_saturated;
        w_givenNext    = r_bonusGiven;
        w_pendingNext  = r_bonusPending;
        if (w_clear) begin
            w_stateNext    = IDLE;
            w_remainNext   = '0;
            w_hundredsNext = 4'd0;
            w_tensNext     = 4'd0;
            w_satNext      = 1'b0;
            w_givenNext    = 1'b0;
            w_pendingNext  = 1'b0;
        end else if (r_state == ADD) begin
            w_hundredsNext = w_incHundreds;
            w_tensNext     = w_incTens;
            if (w_incHundreds == 4'd9 && w_incTens == 4'd9) begin
                w_satNext = 1'b1;
            end
            w_remainNext  = r_remain - RW'(1);
            w_pendingNext = w_bonusReq;
            if (r_remain == RW'(1)) begin
                w_stateNext = IDLE;
            end
        end else if (w_accept) begin
            w_remainNext  = RW'(point_type);
            w_stateNext   = ADD;
            w_pendingNext = w_bonusReq;
        end else if (w_bonusReq) begin
            w_givenNext   = 1'b1;
            w_pendingNext = 1'b0;
            if (w_bonus != '0) begin
                w_remainNext = w_bonus;
                w_stateNext  = ADD;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state        <= IDLE;
            r_remain       <= '0;
            r_hundreds     <= 4'd0;
            r_tens         <= 4'd0;
            r_saturated    <= 1'b0;
            r_bonusGiven   <= 1'b0;
            r_bonusPending <= 1'b0;
            r_prevState    <= 3'd0;
        end else begin
            r_state        <= w_stateNext;
            r_remain       <= w_remainNext;
            r_hundreds     <= w_hundredsNext;
            r_tens         <= w_tensNext;
            r_saturated    <= w_satNext;
            r_bonusGiven   <= w_givenNext;
            r_bonusPending <= w_pendingNext;
            r_prevState    <= curr_state;
        end
    end

endmodule

// File: tb/tb_score_accumulator.sv
// Bench for score_accumulator: directed corner cases plus random point and
// bonus sequences checked against an integer score model.
module tb_score_accumulator;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [2:0] curr_state;
    logic       point_valid;
    logic [1:0] point_type;
    logic [9:0] fire_count;
    logic       point_ready;
    logic [3:0] hundreds;
    logic [3:0] ten_out;
    logic       busy;
    logic       saturated;
    logic       bonus_given;

    int total = 0;
    int bad = 0;
    int modelScore = 0;

    always #5 Clk = ~Clk;

    score_accumulator dut (
        .Clk(Clk),
        .Reset(Reset),
        .curr_state(curr_state),
        .point_valid(point_valid),
        .point_type(point_type),
        .fire_count(fire_count),
        .point_ready(point_ready),
        .hundreds(hundreds),
        .ten_out(ten_out),
        .busy(busy),
        .saturated(saturated),
        .bonus_given(bonus_given)
    );

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [31:0] digitsOf(input int v);
        logic [3:0] h;
        logic [3:0] t;
        h = 4'(v / 10);
        t = 4'(v % 10);
        return {24'd0, h, t};
    endfunction

    function automatic int bonusOf(input int fc);
        if (fc <= 21) return 10;
        if (fc - 21 >= 10) return 0;
        return 10 - (fc - 21);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One kill event of value n, checking every increment step along the way.
    task automatic applyStimulus(input int n, input string tag);
        int base;
        base = modelScore;
        point_valid = 1'b1;
        point_type  = 2'(n);
        tick();
        point_valid = 1'b0;
        point_type  = 2'd0;
        if (n == 0) begin
            checkOutput({tag, "_nop_busy"}, {31'd0, busy}, 32'd0);
            checkOutput({tag, "_nop_digits"}, {24'd0, hundreds, ten_out}, digitsOf(base));
            return;
        end
        checkOutput({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_accept_digits"}, {24'd0, hundreds, ten_out}, digitsOf(base));
        for (int k = 1; k <= n; k++) begin
            tick();
            checkOutput({tag, "_step_digits"}, {24'd0, hundreds, ten_out}, digitsOf(minInt(99, base + k)));
            checkOutput({tag, "_step_busy"}, {31'd0, busy}, (k < n) ? 32'd1 : 32'd0);
        end
        modelScore = minInt(99, base + n);
        checkOutput({tag, "_ready"}, {31'd0, point_ready}, 32'd1);
        checkOutput({tag, "_saturated"}, {31'd0, saturated}, (modelScore == 99) ? 32'd1 : 32'd0);
    endtask

    task automatic addTo(input int target, input string tag);
        while (modelScore < target) begin
            applyStimulus(minInt(3, target - modelScore), tag);
        end
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < maxCycles) begin
            tick();
            n++;
        end
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic clearGame(input string tag);
        curr_state  = 3'd6;
        point_valid = 1'b1;
        point_type  = 2'd3;
        tick();
        point_valid = 1'b0;
        point_type  = 2'd0;
        modelScore  = 0;
        checkOutput({tag, "_clr_digits"}, {24'd0, hundreds, ten_out}, digitsOf(0));
        checkOutput({tag, "_clr_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_clr_sat"}, {31'd0, saturated}, 32'd0);
        checkOutput({tag, "_clr_given"}, {31'd0, bonus_given}, 32'd0);
        checkOutput({tag, "_clr_ready"}, {31'd0, point_ready}, 32'd0);
        curr_state = 3'd3;
        tick();
        checkOutput({tag, "_run_ready"}, {31'd0, point_ready}, 32'd1);
    endtask

    task automatic winBonus(input int fc, input string tag);
        int b;
        b = bonusOf(fc);
        fire_count = 10'(fc);
        curr_state = 3'd4;
        tick();
        checkOutput({tag, "_win_busy"}, {31'd0, busy}, (b > 0) ? 32'd1 : 32'd0);
        waitIdle(20, tag);
        modelScore = minInt(99, modelScore + b);
        checkOutput({tag, "_bonus_digits"}, {24'd0, hundreds, ten_out}, digitsOf(modelScore));
        checkOutput({tag, "_bonus_given"}, {31'd0, bonus_given}, 32'd1);
        curr_state = 3'd3;
        tick();
    endtask

    initial begin
        int n;
        Reset       = 1'b0;
        curr_state  = 3'd3;
        point_valid = 1'b0;
        point_type  = 2'd0;
        fire_count  = 10'd0;
        #12;
        checkOutput("rst_digits", {24'd0, hundreds, ten_out}, digitsOf(0));
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ready", {31'd0, point_ready}, 32'd1);
        checkOutput("rst_sat", {31'd0, saturated}, 32'd0);
        checkOutput("rst_given", {31'd0, bonus_given}, 32'd0);
        Reset = 1'b1;
        tick();

        applyStimulus(3, "turquoise_from0");
        applyStimulus(3, "build60");
        applyStimulus(3, "build90");
        applyStimulus(0, "type0");
        applyStimulus(2, "carry90");

        for (int i = 0; i < 60 && modelScore < 80; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), "rand_pt");
        end
        addTo(98, "to98");
        applyStimulus(3, "saturate");
        applyStimulus(1, "sat_hold");

        clearGame("g1");
        addTo(42, "to42");
        winBonus(24, "bonus24");
        curr_state = 3'd4;
        tick();
        checkOutput("reenter_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("reenter_digits", {24'd0, hundreds, ten_out}, digitsOf(modelScore));
        curr_state = 3'd3;
        tick();

        for (int i = 0; i < 4; i++) begin
            clearGame("rg");
            addTo(int'($urandom_range(0, 95)), "rand_to");
            winBonus(int'($urandom_range(0, 40)), "rand_bonus");
        end

        clearGame("g2");
        curr_state  = 3'd4;
        fire_count  = 10'd40;
        point_valid = 1'b1;
        point_type  = 2'd1;
        tick();
        point_valid = 1'b0;
        point_type  = 2'd0;
        checkOutput("simul_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (bonus_given !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("simul_given", {31'd0, bonus_given}, 32'd1);
        waitIdle(10, "simul");
        modelScore = 1;
        checkOutput("simul_digits", {24'd0, hundreds, ten_out}, digitsOf(modelScore));

        curr_state  = 3'd3;
        tick();
        point_valid = 1'b1;
        point_type  = 2'd3;
        tick();
        point_valid = 1'b0;
        point_type  = 2'd0;
        tick();
        checkOutput("midadd_busy", {31'd0, busy}, 32'd1);
        curr_state = 3'd6;
        tick();
        checkOutput("abort_digits", {24'd0, hundreds, ten_out}, digitsOf(0));
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_given", {31'd0, bonus_given}, 32'd0);
        curr_state = 3'd3;
        modelScore = 0;
        tick();

        addTo(3, "pre_rst");
        fire_count = 10'd5;
        curr_state = 3'd4;
        tick();
        tick();
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd1);
        checkOutput("rstmid_given", {31'd0, bonus_given}, 32'd1);
        Reset = 1'b0;
        #1;
        checkOutput("async_digits", {24'd0, hundreds, ten_out}, digitsOf(0));
        checkOutput("async_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_given", {31'd0, bonus_given}, 32'd0);
        checkOutput("async_ready", {31'd0, point_ready}, 32'd1);
        curr_state = 3'd3;
        #2;
        Reset = 1'b1;
        modelScore = 0;
        tick();
        checkOutput("post_rst_digits", {24'd0, hundreds, ten_out}, digitsOf(0));
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
        applyStimulus(2, "post_rst_pt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
